// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: UART receiver with 16x oversampling, start-glitch
// rejection and mid-bit sampling. The default frame is 8-N-1.
// Define UART_RX_PARITY_EN for 8-E-1 framing with an even-parity check on parity_err.
module uart_rx_decoder #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          s_meta;
  logic          s_in;
  logic          s_prev;
  logic [PW-1:0] pcnt;
  logic [3:0]    tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          start_det;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  assign tick      = (pcnt == PW'(BAUD_DIV - 1));
  assign start_det = (state == IDLE) && s_prev && !s_in;
  assign rx_busy   = (state != IDLE);

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= ser_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end

  // Oversample prescaler, held at zero while idle so the first tick lands BAUD_DIV cycles after start detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (state == IDLE || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Frame state machine: samples mid-bit, shifts data in LSB first, and issues the one-cycle result strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= 4'd0;
      bcnt       <= 3'd0;
      shreg      <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state <= START;
            tcnt  <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == 4'd7) begin
              if (s_in) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                tcnt  <= 4'd0;
                bcnt  <= 3'd0;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              shreg <= {s_in, shreg[7:1]};
              bcnt  <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              par_bit <= s_in;
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              state <= IDLE;
              if (s_in) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^shreg) ^ par_bit;
`endif
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb_uart_rx_decoder: directed and randomized frames driven onto ser_in,
// with expectations taken from a byte-level model of the link.
// The parity cases are only built when UART_RX_PARITY_EN is defined.
module tb_uart_rx_decoder;

  localparam int BAUD_DIV = 27;
  localparam int BIT      = 16 * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned valid_cyc = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;

  // Byte-level reference state: what the link should have delivered so far.
  int         exp_valid = 0;
  int         exp_ferr  = 0;
  int         exp_perr  = 0;
  logic [7:0] exp_data  = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       bad_parity = 1'b0;
`endif

  uart_rx_decoder #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_in     (ser_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #10 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err)  n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
  end

  // Bounded run time: a hang is reported and stops the run.
  initial begin
    repeat (80000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [10:0] makeFrame(input logic [7:0] data, input logic stop_bit);
    logic [10:0] f;
`ifdef UART_RX_PARITY_EN
    f = {stop_bit, (^data) ^ bad_parity, data, 1'b0};
`else
    f = {1'b0, stop_bit, data, 1'b0};
`endif
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run = tests_run + 1;
    assert (observed === expected) else begin
      tests_failed = tests_failed + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the first nsend bits of a frame, each bit_cycles long, starting on a falling clock edge.
  task automatic applyStimulus(input logic [10:0] frame, input int nsend, input int bit_cycles);
    @(negedge clk);
    fall_cyc = cyc;
    for (int i = 0; i < nsend; i++) begin
      ser_in = frame[i];
      repeat (bit_cycles) @(negedge clk);
    end
  endtask

  task automatic idleLine(input int cycles);
    ser_in = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectGood(input logic [7:0] data);
    exp_valid = exp_valid + 1;
    exp_data  = data;
  endtask

  initial begin
    int diff;
    logic [7:0] b;
    int bc;

    ser_in = 1'b1;
    reset  = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_rx_data",    32'(rx_data),    32'h00);
    checkOutput("reset_rx_valid",   32'(rx_valid),   32'h0);
    checkOutput("reset_frame_err",  32'(frame_err),  32'h0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
    checkOutput("reset_rx_busy",    32'(rx_busy),    32'h0);
    idleLine(20);

    applyStimulus(makeFrame(8'h55, 1'b1), FRAME_BITS, BIT);
    expectGood(8'h55);
    checkOutput("x55_valid_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("x55_data",        32'(rx_data), 32'(exp_data));
    checkOutput("x55_ferr_count",  32'(n_ferr),  32'(exp_ferr));
    diff = int'(valid_cyc - fall_cyc);
`ifdef UART_RX_PARITY_EN
    checkOutput("x55_latency_in_window", 32'((diff >= 168*BAUD_DIV+1) && (diff <= 168*BAUD_DIV+3)), 32'h1);
`else
    checkOutput("x55_latency_in_window", 32'((diff >= 152*BAUD_DIV+1) && (diff <= 152*BAUD_DIV+3)), 32'h1);
`endif
    checkOutput("x55_busy_after", 32'(rx_busy), 32'h0);

    applyStimulus(makeFrame(8'hA3, 1'b1), FRAME_BITS, BIT);
    expectGood(8'hA3);
    checkOutput("b2b_first_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("b2b_first_data",  32'(rx_data), 32'(exp_data));
    applyStimulus(makeFrame(8'h0F, 1'b1), FRAME_BITS, BIT);
    expectGood(8'h0F);
    checkOutput("b2b_second_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("b2b_second_data",  32'(rx_data), 32'(exp_data));
    checkOutput("b2b_ferr_count",   32'(n_ferr),  32'(exp_ferr));
    idleLine(50);

    for (int g = 0; g < 4; g++) begin
      ser_in = 1'b0;
      repeat (25) @(negedge clk);
      idleLine(300);
      checkOutput($sformatf("glitch%0d_busy", g), 32'(rx_busy), 32'h0);
    end
    checkOutput("glitch_valid_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("glitch_ferr_count",  32'(n_ferr),  32'(exp_ferr));

    applyStimulus(makeFrame(8'h3C, 1'b0), FRAME_BITS, BIT);
    ser_in = 1'b0;
    repeat (BIT) @(negedge clk);
    exp_ferr = exp_ferr + 1;
    checkOutput("ferr_count",       32'(n_ferr),  32'(exp_ferr));
    checkOutput("ferr_valid_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("ferr_data_kept",   32'(rx_data), 32'(exp_data));
    checkOutput("ferr_held_low_idle", 32'(rx_busy), 32'h0);
    idleLine(2 * BIT);
    checkOutput("ferr_no_retrigger", 32'(n_valid + n_ferr), 32'(exp_valid + exp_ferr));

    applyStimulus(makeFrame(8'hFF, 1'b1), 5, BIT);
    ser_in = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_data = 8'h00;
    idleLine(2 * BIT);
    checkOutput("abort_busy",        32'(rx_busy), 32'h0);
    checkOutput("abort_valid_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("abort_data_reset",  32'(rx_data), 32'(exp_data));
    applyStimulus(makeFrame(8'h81, 1'b1), FRAME_BITS, BIT);
    expectGood(8'h81);
    checkOutput("after_abort_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("after_abort_data",  32'(rx_data), 32'(exp_data));

`ifdef UART_RX_PARITY_EN
    bad_parity = 1'b0;
    applyStimulus(makeFrame(8'h07, 1'b1), FRAME_BITS, BIT);
    expectGood(8'h07);
    checkOutput("par_good_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("par_good_perr",  32'(n_perr),  32'(exp_perr));
    bad_parity = 1'b1;
    applyStimulus(makeFrame(8'h07, 1'b1), FRAME_BITS, BIT);
    bad_parity = 1'b0;
    expectGood(8'h07);
    exp_perr = exp_perr + 1;
    checkOutput("par_bad_count", 32'(n_valid), 32'(exp_valid));
    checkOutput("par_bad_perr",  32'(n_perr),  32'(exp_perr));
    checkOutput("par_bad_data",  32'(rx_data), 32'(exp_data));
`endif

    for (int r = 0; r < 5; r++) begin
      b  = 8'($urandom_range(0, 255));
      bc = int'($urandom_range(420, 444));
      idleLine(int'($urandom_range(0, 300)));
      applyStimulus(makeFrame(b, 1'b1), FRAME_BITS, bc);
      expectGood(b);
      checkOutput($sformatf("rand%0d_count", r), 32'(n_valid), 32'(exp_valid));
      checkOutput($sformatf("rand%0d_data", r),  32'(rx_data), 32'(exp_data));
    end
    checkOutput("final_ferr_count", 32'(n_ferr), 32'(exp_ferr));
    checkOutput("final_perr_count", 32'(n_perr), 32'(exp_perr));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
